// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: serializes an accepted 8-bit word by stepping the select of an
// external combinational 8:1 bit mux and registering each returned bit.
// Optional feature: define MUX_SCAN_PARITY_EN to append an even-parity bit
// (ninth pulse, carries ser_last) after the eight data bits.
module mux_scan_ctrl #(
    parameter int unsigned LSB_FIRST  = 1,
    parameter int unsigned GAP_CYCLES = 0    // 0..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] word_in,
    input  logic       word_valid,
    output logic       word_ready,
    output logic [7:0] mux_in,
    output logic [2:0] mux_sel,
    input  logic       mux_out,
    output logic       ser_bit,
    output logic       ser_valid,
    output logic       ser_last,
    output logic       busy
);

    localparam int unsigned GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [7:0]  GAP_LAST   = 8'(GAP_LAST_I);
    localparam bit          HAS_GAP    = (GAP_CYCLES > 0);
    localparam logic [2:0]  SEL_FIRST  = (LSB_FIRST != 0) ? 3'd0 : 3'd7;
    localparam logic [2:0]  BIT_LAST   = 3'd7;

`ifdef MUX_SCAN_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

    state_t     state;
    logic [7:0] gap_cnt;
    logic [2:0] bit_cnt;
`ifdef MUX_SCAN_PARITY_EN
    logic       acc;        // running XOR of the sampled data bits
    logic       par_pend;   // data bits done; the gap leads into PARITY
`endif

    // Ready is decoded straight from the state register.
    assign word_ready = (state == IDLE);
    assign busy       = ~word_ready;

    // Scan sequencer: accept, step select, register each mux bit, insert gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mux_in    <= 8'd0;
            mux_sel   <= 3'd0;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            gap_cnt   <= 8'd0;
            bit_cnt   <= 3'd0;
`ifdef MUX_SCAN_PARITY_EN
            acc       <= 1'b0;
            par_pend  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ser_valid <= 1'b0;
                    ser_last  <= 1'b0;
                    if (word_valid) begin
                        mux_in  <= word_in;
                        mux_sel <= SEL_FIRST;
                        bit_cnt <= 3'd0;
                        gap_cnt <= 8'd0;
`ifdef MUX_SCAN_PARITY_EN
                        acc      <= 1'b0;
                        par_pend <= 1'b0;
`endif
                        state   <= SHIFT;
                    end
                end

                SHIFT: begin
                    ser_bit   <= mux_out;
                    ser_valid <= 1'b1;
                    gap_cnt   <= 8'd0;
`ifdef MUX_SCAN_PARITY_EN
                    acc       <= acc ^ mux_out;
`endif
                    if (bit_cnt != BIT_LAST) begin
                        // Select steps only between bits; it is held after bit 7.
                        if (LSB_FIRST != 0) begin
                            mux_sel <= mux_sel + 3'd1;
                        end else begin
                            mux_sel <= mux_sel - 3'd1;
                        end
                        bit_cnt  <= bit_cnt + 3'd1;
                        ser_last <= 1'b0;
                        if (HAS_GAP) begin
                            state <= GAP;
                        end else begin
                            state <= SHIFT;
                        end
                    end else begin
`ifdef MUX_SCAN_PARITY_EN
                        ser_last <= 1'b0;
                        par_pend <= 1'b1;
                        if (HAS_GAP) begin
                            state <= GAP;
                        end else begin
                            state <= PARITY;
                        end
`else
                        // No gap follows the final data bit.
                        ser_last <= 1'b1;
                        state    <= IDLE;
`endif
                    end
                end

                GAP: begin
                    ser_valid <= 1'b0;
                    ser_last  <= 1'b0;
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= 8'd0;
`ifdef MUX_SCAN_PARITY_EN
                        if (par_pend) begin
                            state <= PARITY;
                        end else begin
                            state <= SHIFT;
                        end
`else
                        state <= SHIFT;
`endif
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end

`ifdef MUX_SCAN_PARITY_EN
                PARITY: begin
                    ser_bit   <= acc;
                    ser_valid <= 1'b1;
                    ser_last  <= 1'b1;
                    par_pend  <= 1'b0;
                    state     <= IDLE;
                end
`endif

                default: begin
                    ser_valid <= 1'b0;
                    ser_last  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: three instances (LSB-first no gap, MSB-first no gap,
// LSB-first with a 2-cycle gap), each closed around a behavioural 8:1 mux.
module tb_mux_scan_ctrl;

    localparam int NI = 3;
    localparam int NV = 10;
    localparam int IDX_F0 = 6;
`ifdef MUX_SCAN_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct packed {
        logic        bit_v;
        logic        last;
        logic [2:0]  sel;
        logic [31:0] at_edge;
    } exp_t;

    typedef struct packed {
        logic [7:0] word;
        logic [7:0] seq_lsb;   // bit k = k-th serial bit when LSB first
        logic [7:0] seq_msb;   // bit k = k-th serial bit when MSB first
        logic       par;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NI-1:0][7:0] word_in;
    logic [NI-1:0][7:0] mux_in;
    logic [NI-1:0][2:0] mux_sel;
    logic [NI-1:0]      word_valid, word_ready, mux_out;
    logic [NI-1:0]      ser_bit, ser_valid, ser_last, busy;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl [NV];
    vec_t cur [NI];
    exp_t sbq [NI][$];
    int   free_at [NI];
    int   accepts [NI];
    int   pulses [NI];
    logic [7:0] acc_word [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            mux_scan_ctrl #(
                .LSB_FIRST  ((g == 1) ? 0 : 1),
                .GAP_CYCLES ((g == 2) ? 2 : 0)
            ) u_dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .word_in    (word_in[g]),
                .word_valid (word_valid[g]),
                .word_ready (word_ready[g]),
                .mux_in     (mux_in[g]),
                .mux_sel    (mux_sel[g]),
                .mux_out    (mux_out[g]),
                .ser_bit    (ser_bit[g]),
                .ser_valid  (ser_valid[g]),
                .ser_last   (ser_last[g]),
                .busy       (busy[g])
            );
            // Behavioural stand-in for the combinational 8:1 mux.
            assign mux_out[g] = mux_in[g][mux_sel[g]];
        end
    endgenerate

    function automatic int lsb_of(input int i);
        return (i == 1) ? 0 : 1;
    endfunction

    function automatic int gap_of(input int i);
        return (i == 2) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d: got %0h expected %0h", name, i, cyc, act, exp);
        end
    endtask

    // Scoreboard push: on a predicted handshake, queue every expected pulse.
    task automatic predict(input int i);
        exp_t       e;
        int         a;
        int         g;
        logic [7:0] seq;
        if (rst_n && word_valid[i] && cyc >= free_at[i]) begin
            a   = cyc + 1;
            g   = gap_of(i);
            seq = (lsb_of(i) != 0) ? cur[i].seq_lsb : cur[i].seq_msb;
            for (int k = 0; k < 8; k++) begin
                e.bit_v   = seq[k];
                e.last    = (k == 7) && !PAR;
                e.sel     = (lsb_of(i) != 0) ? 3'(k) : 3'(7 - k);
                e.at_edge = 32'(a + 1 + k * (g + 1));
                sbq[i].push_back(e);
            end
            if (PAR) begin
                e.bit_v   = cur[i].par;
                e.last    = 1'b1;
                e.sel     = (lsb_of(i) != 0) ? 3'd7 : 3'd0;
                e.at_edge = 32'(a + 1 + 8 * (g + 1));
                sbq[i].push_back(e);
            end
            free_at[i]  = int'(e.at_edge);
            acc_word[i] = cur[i].word;
            accepts[i]++;
        end
    endtask

    // Scoreboard pop/compare at the falling edge.
    task automatic check_dut(input int i);
        exp_t e;
        logic exp_ready;
        if (!rst_n) begin
            chk("rst_word_ready", i, 32'(word_ready[i]), 32'd1);
            chk("rst_busy", i, 32'(busy[i]), 32'd0);
            chk("rst_ser_valid", i, 32'(ser_valid[i]), 32'd0);
            chk("rst_ser_last", i, 32'(ser_last[i]), 32'd0);
            chk("rst_ser_bit", i, 32'(ser_bit[i]), 32'd0);
            chk("rst_mux_in", i, 32'(mux_in[i]), 32'd0);
            chk("rst_mux_sel", i, 32'(mux_sel[i]), 32'd0);
            sbq[i].delete();
            free_at[i] = 0;
        end else begin
            exp_ready = (cyc >= free_at[i]);
            chk("word_ready", i, 32'(word_ready[i]), 32'(exp_ready));
            chk("busy", i, 32'(busy[i]), 32'(!exp_ready));
            if (!exp_ready) chk("mux_in_hold", i, 32'(mux_in[i]), 32'(acc_word[i]));
            if (sbq[i].size() != 0 && sbq[i][0].at_edge == 32'(cyc)) begin
                e = sbq[i].pop_front();
                chk("ser_valid", i, 32'(ser_valid[i]), 32'd1);
                chk("ser_bit", i, 32'(ser_bit[i]), 32'(e.bit_v));
                chk("ser_last", i, 32'(ser_last[i]), 32'(e.last));
                pulses[i]++;
            end else begin
                chk("ser_valid_idle", i, 32'(ser_valid[i]), 32'd0);
                chk("ser_last_idle", i, 32'(ser_last[i]), 32'd0);
            end
            if (sbq[i].size() != 0 && sbq[i][0].at_edge == 32'(cyc + 1))
                chk("mux_sel", i, 32'(mux_sel[i]), 32'(sbq[i][0].sel));
        end
    endtask

    task automatic tick();
        for (int i = 0; i < NI; i++) predict(i);
        @(negedge clk);
        for (int i = 0; i < NI; i++) check_dut(i);
    endtask

    // Assert reset mid-cycle so a zeroed output before the next rising edge proves async reset.
    task automatic assert_rst();
        for (int i = 0; i < NI; i++) predict(i);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) check_dut(i);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) check_dut(i);
    endtask

    // Present a word and hold valid until the model sees it accepted.
    task automatic send(input int i, input int v);
        int n0;
        cur[i]        = tbl[v];
        word_in[i]    = tbl[v].word;
        word_valid[i] = 1'b1;
        n0 = accepts[i];
        for (int t = 0; t < 200 && accepts[i] == n0; t++) tick();
        chk("accept_timeout", i, 32'(accepts[i] - n0), 32'd1);
    endtask

    task automatic drain(input int i);
        word_valid[i] = 1'b0;
        for (int t = 0; t < 300 && sbq[i].size() != 0; t++) tick();
        chk("drain_timeout", i, 32'(sbq[i].size()), 32'd0);
        tick();
    endtask

    initial begin
        int p0;
        tbl[0] = '{8'h1E, 8'h1E, 8'h78, 1'b0};
        tbl[1] = '{8'hFF, 8'hFF, 8'hFF, 1'b0};
        tbl[2] = '{8'h55, 8'h55, 8'hAA, 1'b0};
        tbl[3] = '{8'hAA, 8'hAA, 8'h55, 1'b0};
        tbl[4] = '{8'h07, 8'h07, 8'hE0, 1'b1};
        tbl[5] = '{8'h03, 8'h03, 8'hC0, 1'b0};
        tbl[6] = '{8'hF0, 8'hF0, 8'h0F, 1'b0};
        tbl[7] = '{8'h00, 8'h00, 8'h00, 1'b0};
        tbl[8] = '{8'h80, 8'h80, 8'h01, 1'b1};
        tbl[9] = '{8'h5C, 8'h5C, 8'h3A, 1'b0};
        word_in    = '0;
        word_valid = '0;
        for (int i = 0; i < NI; i++) begin
            free_at[i]  = 0;
            accepts[i]  = 0;
            pulses[i]   = 0;
            acc_word[i] = 8'd0;
            cur[i]      = tbl[0];
        end

        tick();
        tick();
        release_rst();
        repeat (2) tick();

        // Whole table back-to-back on each configuration, valid held high throughout.
        for (int i = 0; i < NI; i++) begin
            for (int v = 0; v < NV; v++) send(i, v);
            drain(i);
        end

        // Reset in the middle of 0xF0 after its third bit.
        p0 = pulses[0];
        send(0, IDX_F0);
        word_valid[0] = 1'b0;
        for (int t = 0; t < 50 && pulses[0] < p0 + 3; t++) tick();
        chk("third_bit_seen", 0, 32'(pulses[0] - p0), 32'd3);
        assert_rst();
        tick();
        release_rst();
        repeat (6) tick();
        send(0, 0);
        drain(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
